ifetch: RTL and testbench

Instruction fetch stage for the picoMIPS core, sitting between the program counter (`pc`) and the instruction decoder. It drives `pc` through `PCincr`/`Branchaddr` and captures the synchronous program-memory word addressed by `PCout`. It presents instructions to the decoder through a valid/ready handshake, with a two-entry buffer that absorbs decoder stalls without losing or duplicating instructions. Branches resolved downstream flush the buffer and redirect `pc`.

---
 rtl/ifetch.sv | 96 +++++++++
 tb/tb_ifetch.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// Instruction fetch: drives pc, captures 1-cycle synchronous imem data into a 2-entry buffer.
// Latency: issue to instr_valid is 2 edges; 1 instr/cycle; stalls hold the PC, br_take flushes.
module ifetch #(
  parameter int Psize = 6,
  parameter int Isize = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Psize-1:0] PCout,
  output logic             PCincr,
  output logic [Psize-1:0] Branchaddr,
  input  logic [Isize-1:0] imem_rdata,
  output logic [Isize-1:0] instr,
  output logic [Psize-1:0] instr_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             br_take,
  input  logic [Psize-1:0] br_target
);

  logic [1:0]       cnt;
  logic             pend;
  logic [Psize-1:0] pend_pc;
  logic [Isize-1:0] ent0_i, ent1_i;
  logic [Psize-1:0] ent0_p, ent1_p;

  logic             pop;
  logic             issue;
  logic [2:0]       occ;
  logic [1:0]       cnt_ap;
  logic [1:0]       n_cnt;
  logic [Isize-1:0] n_ent0_i, n_ent1_i;
  logic [Psize-1:0] n_ent0_p, n_ent1_p;

  assign instr_valid = (cnt != 2'd0);
  assign instr       = ent0_i;
  assign instr_pc    = ent0_p;
  assign pop         = instr_valid & instr_ready;

  // Occupancy counts the in-flight word, so the buffer can never be overrun.
  always_comb begin
    occ        = {1'b0, cnt} + {2'b00, pend};
    issue      = reset & ~br_take & ((occ - {2'b00, pop}) <= 3'd1);
    PCincr     = issue;
    Branchaddr = !reset ? '0 : (br_take ? br_target : PCout);
  end

  always_comb begin
    cnt_ap   = cnt - {1'b0, pop};
    n_cnt    = cnt_ap + {1'b0, pend};
    n_ent0_i = ent0_i;
    n_ent0_p = ent0_p;
    n_ent1_i = ent1_i;
    n_ent1_p = ent1_p;
    if (pop) begin
      n_ent0_i = ent1_i;
      n_ent0_p = ent1_p;
    end
    if (pend) begin
      if (cnt_ap == 2'd0) begin
        n_ent0_i = imem_rdata;
        n_ent0_p = pend_pc;
      end else begin
        n_ent1_i = imem_rdata;
        n_ent1_p = pend_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= 2'd0;
      pend    <= 1'b0;
      pend_pc <= '0;
      ent0_i  <= '0;
      ent0_p  <= '0;
      ent1_i  <= '0;
      ent1_p  <= '0;
    end else if (br_take) begin
      cnt  <= 2'd0;
      pend <= 1'b0;
    end else begin
      cnt    <= n_cnt;
      pend   <= issue;
      ent0_i <= n_ent0_i;
      ent0_p <= n_ent0_p;
      ent1_i <= n_ent1_i;
      ent1_p <= n_ent1_p;
      if (issue) pend_pc <= PCout;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(pend && !br_take && cnt_ap == 2'd2));

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: pc and synchronous memory environment, queue-based reference model,
// per-cycle compare on the falling edge, directed literal checks and a randomized phase.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  PCout;
  logic        PCincr;
  logic [5:0]  Branchaddr;
  logic [23:0] imem_rdata;
  logic [23:0] instr;
  logic [5:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        br_take;
  logic [5:0]  br_target;

  int n_cmp = 0;
  int n_bad = 0;

  logic [23:0] mem [64];

  ifetch #(.Psize(6), .Isize(24)) dut (
    .clk(clk), .reset(reset), .PCout(PCout), .PCincr(PCincr), .Branchaddr(Branchaddr),
    .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .br_take(br_take), .br_target(br_target)
  );

  always #5 clk = ~clk;

  // Environment: the pc register and a 1-cycle synchronous program memory.
  always @(posedge clk or negedge reset) begin
    if (!reset) PCout <= 6'd0;
    else        PCout <= PCincr ? PCout + 6'd1 : Branchaddr;
  end

  always @(posedge clk) imem_rdata <= mem[PCout];

  // Reference model: buffer as queues, one in-flight fetch, expected PC.
  logic [23:0] mq_i [$];
  logic [5:0]  mq_p [$];
  bit          mpend;
  logic [5:0]  mpend_pc;
  logic [5:0]  mpc;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq_i.delete();
      mq_p.delete();
      mpend    = 1'b0;
      mpend_pc = 6'd0;
      mpc      = 6'd0;
    end else begin : model_step
      bit pop;
      bit iss;
      pop = (mq_i.size() != 0) && instr_ready;
      iss = !br_take && (mq_i.size() + int'(mpend) - int'(pop) <= 1);
      if (br_take) begin
        mq_i.delete();
        mq_p.delete();
        mpend = 1'b0;
        mpc   = br_target;
      end else begin
        if (pop) begin
          void'(mq_i.pop_front());
          void'(mq_p.pop_front());
        end
        if (mpend) begin
          mq_i.push_back(mem[mpend_pc]);
          mq_p.push_back(mpend_pc);
        end
        mpend = iss;
        if (iss) begin
          mpend_pc = mpc;
          mpc      = mpc + 6'd1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", 32'(instr), 32'd0);
      chk("rst_instr_pc", 32'(instr_pc), 32'd0);
      chk("rst_pcincr", 32'(PCincr), 32'd0);
      chk("rst_branchaddr", 32'(Branchaddr), 32'd0);
    end else begin : cmp
      bit ev;
      bit pop;
      bit ei;
      ev  = (mq_i.size() != 0);
      pop = ev && instr_ready;
      ei  = !br_take && (mq_i.size() + int'(mpend) - int'(pop) <= 1);
      chk("instr_valid", 32'(instr_valid), 32'(ev));
      if (ev) begin
        chk("instr", 32'(instr), 32'(mq_i[0]));
        chk("instr_pc", 32'(instr_pc), 32'(mq_p[0]));
      end
      chk("pcincr", 32'(PCincr), 32'(ei));
      if (!ei) chk("branchaddr", 32'(Branchaddr), 32'(br_take ? br_target : mpc));
      chk("pcout", 32'(PCout), 32'(mpc));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 24'h000100 + 24'(i);
    reset       = 1'b0;
    instr_ready = 1'b1;
    br_take     = 1'b0;
    br_target   = 6'd0;
    step(3);

    // Reset release and streaming
    reset = 1'b1;
    step(2);
    chk("lit_first_valid", 32'(instr_valid), 32'd1);
    chk("lit_first_instr", 32'(instr), 32'h000100);
    chk("lit_first_pc", 32'(instr_pc), 32'd0);
    chk("lit_first_pcincr", 32'(PCincr), 32'd1);
    step(1);
    chk("lit_second_pc", 32'(instr_pc), 32'd1);
    step(8);

    // Backpressure for 5 cycles
    instr_ready = 1'b0;
    step(5);
    chk("lit_bp_pcincr", 32'(PCincr), 32'd0);
    chk("lit_bp_baddr", 32'(Branchaddr), 32'(PCout));
    instr_ready = 1'b1;
    step(10);

    // Branch to 12
    br_take   = 1'b1;
    br_target = 6'd12;
    #1;
    chk("lit_br_pcincr", 32'(PCincr), 32'd0);
    chk("lit_br_baddr", 32'(Branchaddr), 32'd12);
    step(1);
    br_take = 1'b0;
    chk("lit_br_flush_valid", 32'(instr_valid), 32'd0);
    step(2);
    chk("lit_br_pc", 32'(instr_pc), 32'd12);
    chk("lit_br_instr", 32'(instr), 32'h00010C);
    step(4);

    // Branch while full
    instr_ready = 1'b0;
    step(4);
    br_take   = 1'b1;
    br_target = 6'd3;
    step(1);
    br_take = 1'b0;
    step(2);
    chk("lit_full_br_valid", 32'(instr_valid), 32'd1);
    chk("lit_full_br_pc", 32'(instr_pc), 32'd3);
    chk("lit_full_br_instr", 32'(instr), 32'h000103);
    instr_ready = 1'b1;
    step(5);

    // Wrap from 62 through 0
    br_take   = 1'b1;
    br_target = 6'd62;
    step(1);
    br_take = 1'b0;
    step(2);
    chk("lit_wrap_pc62", 32'(instr_pc), 32'd62);
    chk("lit_wrap_i62", 32'(instr), 32'h00013E);
    step(1);
    chk("lit_wrap_pc63", 32'(instr_pc), 32'd63);
    step(1);
    chk("lit_wrap_pc0", 32'(instr_pc), 32'd0);
    chk("lit_wrap_i0", 32'(instr), 32'h000100);
    step(1);
    chk("lit_wrap_pc1", 32'(instr_pc), 32'd1);
    step(3);

    // Asynchronous reset between edges
    #2;
    reset = 1'b0;
    #1;
    chk("lit_arst_valid", 32'(instr_valid), 32'd0);
    chk("lit_arst_pcincr", 32'(PCincr), 32'd0);
    chk("lit_arst_baddr", 32'(Branchaddr), 32'd0);
    step(2);
    reset = 1'b1;
    step(2);
    chk("lit_restart_valid", 32'(instr_valid), 32'd1);
    chk("lit_restart_instr", 32'(instr), 32'h000100);
    chk("lit_restart_pc", 32'(instr_pc), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      br_take     = ($urandom_range(0, 15) == 0);
      br_target   = 6'($urandom_range(0, 63));
      step(1);
    end
    br_take = 1'b0;
    step(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
